// File: rtl/core_fetch.sv
// Instruction fetch stage: one outstanding imem request, single-entry
// instruction buffer, PC redirect with wrong-path squash.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   imem_req_*          request channel (valid/ready, word-aligned address)
//   imem_rsp_*          response channel (one response per accepted request)
//   redirect_*          taken-branch PC redirect from branch resolution
//   instr_*             buffered instruction and its PC (valid/ready)
//   op/funct3/funct7    pre-split fields of instr
//   retire_count        instructions handed downstream (wraps)
module core_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc,
    output logic [6:0]       op,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [31:0]      retire_count
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]     retire_count_q, retire_count_d;
    logic            req_fire;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            fetch_pc_q     <= RESET_PC;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fetch_pc_q     <= fetch_pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign req_fire = imem_req_valid & imem_req_ready;

    // Next-state logic. A redirect overrides every other event; an
    // in-flight request without its response yet must be drained in FLUSH.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_pc_d     = fetch_pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        retire_count_d = retire_count_q;
        if (redirect_valid) begin
            pc_d = redirect_target & ALIGN_MASK;
            unique case (state_q)
                S_REQ:   state_d = S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
                S_HOLD:  state_d = S_REQ;
                S_FLUSH: state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = fetch_pc_q;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        retire_count_d = retire_count_q + 32'd1;
                        state_d        = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) & ~redirect_valid & ~rst;
        instr_valid    = (state_q == S_HOLD) & ~rst;
    end

    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign op           = instr_q[6:0];
    assign funct3       = instr_q[14:12];
    assign funct7       = instr_q[31:25];
    assign retire_count = retire_count_q;

    // Responses are only legal while a request is outstanding.
    a_rsp_legal: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_FLUSH));

endmodule

// File: tb/tb_core_fetch.sv
// Directed self-checking bench for core_fetch with a small
// latency-configurable instruction memory model.
module tb_core_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_lat     = 1;
    bit          pend        = 0;
    int          cnt         = 0;
    logic [31:0] paddr       = '0;
    bit          special_en  = 0;
    logic [31:0] special_addr = '0;
    logic [31:0] special_word = '0;

    core_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .op              (op),
        .funct3          (funct3),
        .funct7          (funct7),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (special_en && a == special_addr) return special_word;
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory: observes the request just after the falling edge and drives
    // the response mem_lat cycles after the accepting cycle.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            pend           = 0;
            imem_rsp_valid = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    pend           = 0;
                end
            end else if (imem_req_valid && imem_req_ready) begin
                pend  = 1;
                cnt   = mem_lat;
                paddr = imem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (instr_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        step();
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 00", {imem_req_valid, instr_valid});
        end
        n_checks++;
        if ({instr, instr_pc, retire_count} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h want 0", {instr, instr_pc, retire_count});
        end
        step();
        rst = 1'b0;
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid, imem_addr} !== {2'b10, RPC}) begin
            n_fail++;
            $display("FAIL reset_release: got %b %h want 10 %h",
                     {imem_req_valid, instr_valid}, imem_addr, RPC);
        end
    endtask

    task automatic test_fetch_seq();
        logic [31:0] a;
        step();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a = RPC + 32'(4 * (k / 3));
            smp();
            n_checks++;
            case (k % 3)
                0: if ({imem_req_valid, instr_valid} !== 2'b10 || imem_addr !== a) begin
                    n_fail++;
                    $display("FAIL seq_req k=%0d: got %b %h want 10 %h",
                             k, {imem_req_valid, instr_valid}, imem_addr, a);
                end
                1: if ({imem_req_valid, instr_valid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL seq_wait k=%0d: got %b want 00",
                             k, {imem_req_valid, instr_valid});
                end
                default: if ({imem_req_valid, instr_valid} !== 2'b01 ||
                             instr_pc !== a || instr !== mem_word(a)) begin
                    n_fail++;
                    $display("FAIL seq_hold k=%0d: got %b %h %h want 01 %h %h",
                             k, {imem_req_valid, instr_valid}, instr_pc, instr,
                             a, mem_word(a));
                end
            endcase
            step();
        end
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        smp();
        n_checks++;
        if (retire_count !== 32'd3 || imem_addr !== RPC + 32'hC) begin
            n_fail++;
            $display("FAIL seq_retire: got %0d %h want 3 %h",
                     retire_count, imem_addr, RPC + 32'hC);
        end
    endtask

    task automatic test_fields_hold();
        bit ok;
        step();
        special_en = 1;
        special_addr = RPC + 32'hC;
        special_word = 32'h40B5_0533;
        imem_req_ready = 1'b1;
        wait_valid(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fields_timeout: instr_valid got 0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({instr, instr_pc, op, funct3, funct7, instr_valid, imem_req_valid} !==
                {32'h40B5_0533, RPC + 32'hC, 7'h33, 3'h0, 7'h20, 2'b10}) begin
                n_fail++;
                $display("FAIL fields_hold c=%0d: got %h %h %h %h %h %b",
                         i, instr, instr_pc, op, funct3, funct7,
                         {instr_valid, imem_req_valid});
            end
            smp();
        end
        step();
        instr_ready = 1'b1;
        smp();
        step();
        instr_ready = 1'b0;
        imem_req_ready = 1'b0;
        smp();
        n_checks++;
        if (retire_count !== 32'd4 || imem_addr !== RPC + 32'h10 ||
            {imem_req_valid, instr_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL fields_consume: got %0d %h %b want 4 %h 10",
                     retire_count, imem_addr, {imem_req_valid, instr_valid},
                     RPC + 32'h10);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        step();
        mem_lat = 3;
        imem_req_ready = 1'b1;
        smp();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        smp();
        step();
        redirect_valid = 1'b0;
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b00 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rw_flush1: got %b %h want 00 00000200",
                     {imem_req_valid, instr_valid}, imem_addr);
        end
        step();
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rw_flush2: got %b want 00", {imem_req_valid, instr_valid});
        end
        step();
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b10 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rw_req: got %b %h want 10 00000200",
                     {imem_req_valid, instr_valid}, imem_addr);
        end
        step();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        wait_valid(ok);
        n_checks++;
        if (!ok || instr_pc !== 32'h200 || instr !== mem_word(32'h200)) begin
            n_fail++;
            $display("FAIL rw_refetch: got %b %h %h want 1 00000200 %h",
                     ok, instr_pc, instr, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_hold();
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h203;
        instr_ready = 1'b1;
        smp();
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        imem_req_ready = 1'b0;
        smp();
        n_checks++;
        if (retire_count !== 32'd4 || imem_addr !== 32'h200 ||
            {imem_req_valid, instr_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rh_drop: got %0d %h %b want 4 00000200 10",
                     retire_count, imem_addr, {imem_req_valid, instr_valid});
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
                n_fail++;
                $display("FAIL stall c=%0d: got %b %h want 1 00000200",
                         i, imem_req_valid, imem_addr);
            end
            step();
            smp();
        end
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h180;
        smp();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_redir_gate: got %b want 0", imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        smp();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h180) begin
            n_fail++;
            $display("FAIL stall_redir_addr: got %b %h want 1 00000180",
                     imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_wrap();
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        smp();
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        smp();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_addr: got %b %h want 1 fffffffc",
                     imem_req_valid, imem_addr);
        end
        step();
        imem_req_ready = 1'b0;
        smp();
        step();
        smp();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_hold: got %b %h want 1 fffffffc", instr_valid, instr_pc);
        end
        step();
        instr_ready = 1'b1;
        smp();
        step();
        instr_ready = 1'b0;
        smp();
        n_checks++;
        if (imem_addr !== 32'h0 || retire_count !== 32'd5) begin
            n_fail++;
            $display("FAIL wrap_next: got %h %0d want 00000000 5", imem_addr, retire_count);
        end
    endtask

    task automatic test_reset_mid();
        step();
        imem_req_ready = 1'b1;
        smp();
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_gate: got %b want 00", {imem_req_valid, instr_valid});
        end
        step();
        rst = 1'b0;
        smp();
        n_checks++;
        if ({imem_req_valid, instr_valid} !== 2'b10 || imem_addr !== RPC ||
            retire_count !== 32'd0 || instr_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %b %h %0d %h want 10 %h 0 0",
                     {imem_req_valid, instr_valid}, imem_addr, retire_count,
                     instr_pc, RPC);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_fields_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
